// File: rtl/tone_sequencer.sv
// Turns each new sound code into one timed square-wave note followed by a silent gap.
// Reports busy while sounding/gapping and pulses note_done when a note completes.
module tone_sequencer #(
    parameter int NOTE_TICKS   = 2500000,
    parameter int GAP_TICKS    = 250000,
    parameter int HP_DIV_SHIFT = 0,
    parameter int CNT_W        = 24
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [5:0] selection,
    input  logic       sound_reset,
    output logic       audio_out,
    output logic       busy,
    output logic       note_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

    localparam logic [5:0]       SEL_OFF  = 6'h3F;
    localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_END  = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

    state_t           state_q, state_d;
    logic [5:0]       sel_q, sel_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [16:0]      hp_cnt_q, hp_cnt_d;
    logic             audio_q, audio_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [16:0] hp_raw, hp_last;
    logic [5:0]  hp_shift;
    logic        is_tone, chg;

    // Octave-0 half-periods at 25 MHz, C4..B4
    function automatic logic [16:0] note_hp(input logic [3:0] n);
        case (n)
            4'd0:    return 17'd47778;
            4'd1:    return 17'd45097;
            4'd2:    return 17'd42566;
            4'd3:    return 17'd40176;
            4'd4:    return 17'd37922;
            4'd5:    return 17'd35793;
            4'd6:    return 17'd33784;
            4'd7:    return 17'd31888;
            4'd8:    return 17'd30098;
            4'd9:    return 17'd28409;
            4'd10:   return 17'd26815;
            4'd11:   return 17'd25310;
            default: return 17'd1;
        endcase
    endfunction

    assign hp_shift = {4'b0, sel_q[5:4]} + 6'(HP_DIV_SHIFT);
    assign hp_raw   = note_hp(sel_q[3:0]) >> hp_shift;
    assign hp_last  = (hp_raw == 17'd0) ? 17'd0 : hp_raw - 17'd1;
    assign is_tone  = (sel_q[3:0] < 4'd12);
    assign chg      = (selection != sel_q);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            sel_q    <= SEL_OFF;
            dur_q    <= '0;
            hp_cnt_q <= '0;
            audio_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dur_q    <= dur_d;
            hp_cnt_q <= hp_cnt_d;
            audio_q  <= audio_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dur_d    = dur_q;
        hp_cnt_d = hp_cnt_q;
        audio_d  = audio_q;
        done_d   = 1'b0;
        if (sound_reset) begin
            state_d  = IDLE;
            sel_d    = SEL_OFF;
            dur_d    = '0;
            hp_cnt_d = '0;
            audio_d  = 1'b0;
        end else if (chg) begin
            // Any new code, even mid-note or mid-gap, restarts from a clean note
            sel_d    = selection;
            dur_d    = '0;
            hp_cnt_d = '0;
            audio_d  = 1'b0;
            state_d  = (selection == SEL_OFF) ? IDLE : PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    if (dur_q == NOTE_END) begin
                        dur_d    = '0;
                        hp_cnt_d = '0;
                        audio_d  = 1'b0;
                        if (GAP_TICKS == 0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        dur_d = dur_q + 1'b1;
                        if (!is_tone) begin
                            hp_cnt_d = '0;
                            audio_d  = 1'b0;
                        end else if (hp_cnt_q == hp_last) begin
                            hp_cnt_d = '0;
                            audio_d  = ~audio_q;
                        end else begin
                            hp_cnt_d = hp_cnt_q + 17'd1;
                        end
                    end
                end
                GAP: begin
                    audio_d  = 1'b0;
                    hp_cnt_d = '0;
                    if (dur_q == GAP_END) begin
                        dur_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    dur_d    = '0;
                    hp_cnt_d = '0;
                    audio_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d != IDLE);
    end

    assign audio_out = audio_q;
    assign busy      = busy_q;
    assign note_done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: each note queues its expected audio/busy/done edges; a negedge
// monitor pops and compares them. A second GAP_TICKS=0 instance is checked directly.
module tb_tone_sequencer;

    localparam int NT  = 2000;
    localparam int GT  = 200;
    localparam int HDS = 8;

    typedef struct {
        int cyc;
        int kind;   // 0 audio, 1 busy, 2 note_done
        int val;
    } ev_t;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic [5:0] selection = 6'h3F;
    logic       sound_reset = 1'b0;
    logic       audio_out, busy, note_done;

    logic       rst0 = 1'b1;
    logic [5:0] sel0 = 6'h3F;
    logic       sres0 = 1'b0;
    logic       audio0, busy0, done0;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    ev_t exp_q[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    tone_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .HP_DIV_SHIFT(HDS), .CNT_W(24)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .selection(selection), .sound_reset(sound_reset),
        .audio_out(audio_out), .busy(busy), .note_done(note_done)
    );

    tone_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(0), .HP_DIV_SHIFT(HDS), .CNT_W(24)) u_dut0 (
        .PCLK(PCLK), .PRESET(rst0), .selection(sel0), .sound_reset(sres0),
        .audio_out(audio0), .busy(busy0), .note_done(done0)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    endtask

    function automatic int exp_hp(input logic [5:0] s);
        int t[12] = '{47778, 45097, 42566, 40176, 37922, 35793,
                      33784, 31888, 30098, 28409, 26815, 25310};
        int h;
        if (s[3:0] >= 4'd12) return 0;
        h = t[s[3:0]] >> (int'(s[5:4]) + HDS);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic push(input int c, input int k, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        exp_q.push_back(e);
    endtask

    // Queue events of a note whose change is seen at edge e; abort!=0 cuts it at that edge
    task automatic gen_note(input int e, input logic [5:0] s, input int abort, input bit first);
        int  hp;
        bit  lvl;
        hp  = exp_hp(s);
        lvl = 1'b0;
        if (first) push(e, 1, 1);
        if (hp > 0) begin
            for (int t = e + hp; t <= e + NT - 1; t += hp) begin
                if (abort != 0 && t >= abort) break;
                lvl = ~lvl;
                push(t, 0, int'(lvl));
            end
        end
        if (abort != 0) begin
            if (lvl) push(abort, 0, 0);
        end else begin
            if (lvl) push(e + NT, 0, 0);
            push(e + NT + GT, 1, 0);
            push(e + NT + GT, 2, 1);
        end
    endtask

    task automatic see(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("spurious_event_kind", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_val", val, e.val);
        end
    endtask

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (audio_out !== prev_a) begin
                see(0, int'(audio_out));
                prev_a = audio_out;
            end
            if (busy !== prev_b) begin
                see(1, int'(busy));
                prev_b = busy;
            end
            if (note_done) see(2, 1);
        end
    end

    initial begin
        int e, e0, rise, dn, ndone;
        bit found;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_audio", int'(audio_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(note_done), 0);
        PRESET = 1'b0;
        rst0   = 1'b0;
        repeat (10000) @(negedge PCLK);
        chk("idle_busy", int'(busy), 0);

        // Plain tone C oct0
        @(negedge PCLK); selection = 6'h00; e = cyc + 1;
        gen_note(e, 6'h00, 0, 1'b1);
        repeat (2300) @(negedge PCLK);

        // A oct1, same-code rewrite, then retrigger with C oct1 at +500
        @(negedge PCLK); selection = 6'h19; e = cyc + 1;
        gen_note(e, 6'h19, e + 500, 1'b1);
        repeat (300) @(negedge PCLK); selection = 6'h19;
        repeat (200) @(negedge PCLK); selection = 6'h10;
        gen_note(e + 500, 6'h10, 0, 1'b0);
        repeat (2300) @(negedge PCLK);

        // Rest code
        @(negedge PCLK); selection = 6'h0C; e = cyc + 1;
        gen_note(e, 6'h0C, 0, 1'b1);
        repeat (2300) @(negedge PCLK);

        // sound_reset mid-note, then replay after release
        @(negedge PCLK); selection = 6'h05; e = cyc + 1;
        gen_note(e, 6'h05, e + 700, 1'b1);
        push(e + 700, 1, 0);
        repeat (700) @(negedge PCLK); sound_reset = 1'b1;
        @(negedge PCLK); sound_reset = 1'b0;
        gen_note(e + 701, 6'h05, 0, 1'b1);
        repeat (2300) @(negedge PCLK);

        // GAP_TICKS=0 instance
        @(negedge PCLK); sel0 = 6'h30; e0 = cyc + 1;
        rise = -1; dn = -1; ndone = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge PCLK);
            if (audio0 && rise < 0) rise = cyc;
            if (done0) begin ndone++; dn = cyc; end
        end
        chk("g0_first_toggle", rise - e0, 23);
        chk("g0_done_latency", dn - e0, NT);
        chk("g0_done_count", ndone, 1);
        chk("g0_busy_after", int'(busy0), 0);

        // Async PRESET while the tone is high
        @(negedge PCLK); sel0 = 6'h31;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (audio0) begin found = 1'b1; break; end
        end
        chk("g0_tone_high", int'(found), 1);
        chk("g0_busy_mid", int'(busy0), 1);
        #2 rst0 = 1'b1;
        #1;
        chk("g0_async_audio", int'(audio0), 0);
        chk("g0_async_busy", int'(busy0), 0);
        sel0 = 6'h3F;
        @(negedge PCLK); rst0 = 1'b0;
        repeat (5) @(negedge PCLK);
        chk("g0_post_done", int'(done0), 0);
        chk("g0_post_busy", int'(busy0), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
